// File: rtl/morse_receiver_if.sv
// morse_receiver_if: line input, history control and symbol outputs of the Morse receiver
//   morse_raw        raw asynchronous Morse line, 1 = mark
//   clear_history    1-cycle request to clear history and length
//   morse_code_in    debounced line level
//   receive_history  last 8 symbols, bit0 newest, 1 = dash
//   history_len      valid symbols in history, 0..8
//   symbol_valid     1-cycle pulse when a symbol is shifted in
//   symbol           last symbol value, held between pulses
//   char_end         1-cycle pulse when the inter-character gap is reached
//   mark_error       1-cycle pulse when an over-long mark is dropped
interface morse_receiver_if;
    logic       morse_raw;
    logic       clear_history;
    logic       morse_code_in;
    logic [7:0] receive_history;
    logic [3:0] history_len;
    logic       symbol_valid;
    logic       symbol;
    logic       char_end;
    logic       mark_error;
    modport slave (
        input  morse_raw, clear_history,
        output morse_code_in, receive_history, history_len, symbol_valid, symbol, char_end, mark_error
    );
    modport master (
        output morse_raw, clear_history,
        input  morse_code_in, receive_history, history_len, symbol_valid, symbol, char_end, mark_error
    );
endinterface

// File: rtl/morse_receiver.sv
// morse_receiver: sync/debounce a Morse line, time marks and gaps, classify dot/dash, keep history
//   clk  system clock
//   rst  synchronous reset, active high
//   bus  morse_receiver_if.slave: raw line and clear request in; debounced level, history,
//        length, symbol pulse/value, char_end and mark_error pulses out
module morse_receiver #(
    parameter int UNIT_CYCLES     = 5000000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DASH_UNITS      = 2,
    parameter int MAX_MARK_UNITS  = 7,
    parameter int GAP_UNITS       = 3
) (
    input logic              clk,
    input logic              rst,
    morse_receiver_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] UNIT_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [3:0]    DASH_U    = 4'(DASH_UNITS);
    localparam logic [3:0]    MAX_U     = 4'(MAX_MARK_UNITS);
    localparam logic [3:0]    GAP_U     = 4'(GAP_UNITS);

    typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

    state_t        state, state_n;
    logic          sync1, sync2, stable, stable_d;
    logic [DW-1:0] deb_cnt;
    logic [CW-1:0] cyc;
    logic [3:0]    units;
    logic          rise, fall;
    logic          shift, sym_n, char_end_n, err_n;
    logic [7:0]    history;
    logic [3:0]    len;
    logic          symbol_valid, symbol, char_end, mark_error;

    // Two-flop synchroniser followed by a symmetric debouncer, so the
    // debounced pulse width equals the raw pulse width.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= bus.morse_raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable)
                deb_cnt <= '0;
            else if (deb_cnt == DEB_LAST) begin
                stable  <= sync2;
                deb_cnt <= '0;
            end else
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    // Edges are seen one cycle after stable changes, so the timer restarts at 1
    // to count that first cycle; units then equals whole units of the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc   <= '0;
            units <= '0;
        end else if (rise | fall) begin
            cyc   <= CW'(1);
            units <= '0;
        end else if (cyc == UNIT_LAST) begin
            cyc   <= '0;
            units <= (units == 4'hF) ? units : units + 4'd1;
        end else
            cyc <= cyc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        shift      = 1'b0;
        sym_n      = symbol;
        char_end_n = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: state_n = rise ? MARK : IDLE;
            MARK: begin
                if (fall) begin
                    if (units <= MAX_U) begin
                        shift   = 1'b1;
                        sym_n   = units >= DASH_U;
                        state_n = GAP;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                if (rise)
                    state_n = MARK;
                else if (units >= GAP_U) begin
                    char_end_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // clear_history takes priority over a shift in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            history      <= '0;
            len          <= '0;
            symbol_valid <= 1'b0;
            symbol       <= 1'b0;
            char_end     <= 1'b0;
            mark_error   <= 1'b0;
        end else begin
            symbol_valid <= shift;
            symbol       <= sym_n;
            char_end     <= char_end_n;
            mark_error   <= err_n;
            if (bus.clear_history) begin
                history <= '0;
                len     <= '0;
            end else if (shift) begin
                history <= {history[6:0], sym_n};
                len     <= (len == 4'd8) ? len : len + 4'd1;
            end
        end
    end

    assign bus.morse_code_in   = stable_d;
    assign bus.receive_history = history;
    assign bus.history_len     = len;
    assign bus.symbol_valid    = symbol_valid;
    assign bus.symbol          = symbol;
    assign bus.char_end        = char_end;
    assign bus.mark_error      = mark_error;
endmodule

// File: tb/tb_morse_receiver.sv
// tb_morse_receiver: directed bench for morse_receiver with 10-cycle units and 4-cycle debounce
module tb_morse_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   n_sv = 0, n_ce = 0, n_err = 0, n_mc = 0;
    int   t_fall = -1, t_ce = -1;
    logic mc_prev = 1'b0;
    int   sv0, ce0, err0, mc0;

    morse_receiver_if bus();

    morse_receiver #(.UNIT_CYCLES(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (bus.symbol_valid) n_sv++;
        if (bus.char_end) begin
            n_ce++;
            t_ce = cycle;
        end
        if (bus.mark_error) n_err++;
        if (bus.morse_code_in) n_mc++;
        if (mc_prev && !bus.morse_code_in) t_fall = cycle;
        mc_prev = bus.morse_code_in;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark(input int n);
        bus.morse_raw = 1'b1;
        tick(n);
        bus.morse_raw = 1'b0;
    endtask

    task automatic snap();
        sv0  = n_sv;
        ce0  = n_ce;
        err0 = n_err;
        mc0  = n_mc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mc"}, 32'(bus.morse_code_in), 0);
        chk({tag, "_hist"}, 32'(bus.receive_history), 0);
        chk({tag, "_len"}, 32'(bus.history_len), 0);
        chk({tag, "_pulses"}, {29'd0, bus.symbol_valid, bus.char_end, bus.mark_error}, 0);
        chk({tag, "_sym"}, 32'(bus.symbol), 0);
    endtask

    initial begin
        bus.morse_raw     = 1'b1;
        bus.clear_history = 1'b0;
        rst = 1'b1;
        tick(3);
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick(6);
        chk("rise_early", 32'(bus.morse_code_in), 0);
        tick(1);
        chk("rise_on_time", 32'(bus.morse_code_in), 1);
        bus.morse_raw = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);

        snap();
        mark(3);
        tick(20);
        chk("glitch_mc", 32'(n_mc - mc0), 0);
        chk("glitch_sv", 32'(n_sv - sv0), 0);
        chk("glitch_hist", 32'(bus.receive_history), 0);

        snap();
        mark(15);
        tick(10);
        chk("dot_sv", 32'(n_sv - sv0), 1);
        chk("dot_sym", 32'(bus.symbol), 0);
        chk("dot_hist", 32'(bus.receive_history), 8'h00);
        chk("dot_len", 32'(bus.history_len), 1);
        tick(30);
        mark(35);
        tick(10);
        chk("dash_sym", 32'(bus.symbol), 1);
        chk("dash_hist", 32'(bus.receive_history), 8'h01);
        chk("dash_len", 32'(bus.history_len), 2);
        tick(40);

        bus.clear_history = 1'b1;
        tick(1);
        bus.clear_history = 1'b0;
        chk("clear_hist", 32'(bus.receive_history), 0);
        chk("clear_len", 32'(bus.history_len), 0);
        snap();
        mark(15);
        tick(15);
        mark(35);
        tick(15);
        mark(35);
        tick(15);
        mark(15);
        tick(50);
        chk("char_hist", 32'(bus.receive_history[3:0]), 4'b0110);
        chk("char_len", 32'(bus.history_len), 4);
        chk("char_end_count", 32'(n_ce - ce0), 1);
        chk("char_end_delay", 32'(t_ce - t_fall), 30);

        for (int i = 0; i < 8; i++) begin
            mark(i[0] ? 79 : 20);
            tick(15);
        end
        mark(19);
        tick(15);
        chk("full_hist", 32'(bus.receive_history), 8'hFE);
        chk("full_len", 32'(bus.history_len), 8);
        chk("dot19_sym", 32'(bus.symbol), 0);
        snap();
        mark(80);
        tick(50);
        chk("err_count", 32'(n_err - err0), 1);
        chk("err_sv", 32'(n_sv - sv0), 0);
        chk("err_hist", 32'(bus.receive_history), 8'hFE);
        chk("err_no_char_end", 32'(n_ce - ce0), 0);

        mark(15);
        tick(6);
        bus.clear_history = 1'b1;
        tick(1);
        bus.clear_history = 1'b0;
        chk("clr_shift_sv", 32'(bus.symbol_valid), 1);
        chk("clr_shift_hist", 32'(bus.receive_history), 0);
        chk("clr_shift_len", 32'(bus.history_len), 0);
        tick(50);

        snap();
        bus.morse_raw = 1'b1;
        tick(20);
        rst = 1'b1;
        bus.morse_raw = 1'b0;
        tick(3);
        chk_idle_outputs("midrst");
        rst = 1'b0;
        tick(60);
        chk("midrst_sv", 32'(n_sv - sv0), 0);
        chk("midrst_ce", 32'(n_ce - ce0), 0);
        chk("midrst_err", 32'(n_err - err0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
